// File: rtl/layer_sequencer.sv
// Frame sequencer: launches each inference stage in order, hands it the shared buffers, and times the frame.
// Define SEQ_TIMEOUT_EN to add a per-stage watchdog that parks a hung frame in FAULT.
module layer_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CYC_W          = 32,
    localparam int STAGE_W       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [STAGE_W-1:0]    stage_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CYC_W-1:0]      last_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FAULT
    } state_t;

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

    state_t                  state_q, state_d;
    logic [STAGE_W-1:0]      stage_sel_q, stage_sel_d;
    logic [NUM_STAGES-1:0]   stage_start_q, stage_start_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [CYC_W-1:0]        last_cycles_q, last_cycles_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic [CYC_W-1:0]        cyc_inc;
    logic                    sel_done;

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            error_q, error_d;
`endif

    // Only the selected stage's done bit matters; the others are masked off.
    assign sel_done = |(stage_done & (NUM_STAGES'(1) << stage_sel_q));
    assign cyc_inc  = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);

    always_comb begin
        state_d       = state_q;
        stage_sel_d   = stage_sel_q;
        stage_start_d = '0;
        done_d        = 1'b0;
        last_cycles_d = last_cycles_q;
        cyc_d         = cyc_q;
`ifdef SEQ_TIMEOUT_EN
        wd_d          = wd_q;
        error_d       = error_q;
`endif

        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                if (start && !abort) begin
                    state_d     = S_LAUNCH;
                    stage_sel_d = '0;
                end
            end
            S_LAUNCH: begin
                cyc_d   = cyc_inc;
                state_d = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            S_WAIT: begin
                cyc_d = cyc_inc;
                if (sel_done) begin
                    if (stage_sel_q == LAST_STAGE) begin
                        state_d       = S_IDLE;
                        stage_sel_d   = '0;
                        done_d        = 1'b1;
                        last_cycles_d = cyc_inc;
                    end else begin
                        state_d     = S_LAUNCH;
                        stage_sel_d = stage_sel_q + STAGE_W'(1);
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                // A done landing on the final allowed cycle still wins over the timeout.
                else if (wd_q == WD_LAST) begin
                    state_d = S_FAULT;
                    error_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            S_FAULT: begin
                cyc_d = '0;
                if (start) begin
                    state_d     = S_LAUNCH;
                    stage_sel_d = '0;
`ifdef SEQ_TIMEOUT_EN
                    error_d     = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d       = S_IDLE;
            stage_sel_d   = '0;
            done_d        = 1'b0;
            last_cycles_d = last_cycles_q;
`ifdef SEQ_TIMEOUT_EN
            error_d       = 1'b0;
`endif
        end

        if (state_d == S_LAUNCH) begin
            stage_start_d = NUM_STAGES'(1) << stage_sel_d;
        end
        busy_d = (state_d == S_LAUNCH) || (state_d == S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            stage_sel_q   <= '0;
            stage_start_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            last_cycles_q <= '0;
            cyc_q         <= '0;
`ifdef SEQ_TIMEOUT_EN
            wd_q          <= '0;
            error_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            stage_sel_q   <= stage_sel_d;
            stage_start_q <= stage_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            last_cycles_q <= last_cycles_d;
            cyc_q         <= cyc_d;
`ifdef SEQ_TIMEOUT_EN
            wd_q          <= wd_d;
            error_q       <= error_d;
`endif
        end
    end

    assign stage_start = stage_start_q;
    assign stage_sel   = stage_sel_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign last_cycles = last_cycles_q;
`ifdef SEQ_TIMEOUT_EN
    assign error       = error_q;
`else
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Vector-driven bench for layer_sequencer with 3 stages and a 16-cycle watchdog limit.
// Each vector holds the inputs for one cycle and the outputs expected during that same cycle.
module tb_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  stage_done = '0;
    logic [2:0]  stage_start;
    logic [1:0]  stage_sel;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] last_cycles;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        rst;
        logic        st;
        logic        ab;
        logic [2:0]  sd;
        logic [2:0]  ss;
        logic [1:0]  sel;
        logic        bsy;
        logic        dn;
        logic        err;
        logic [31:0] last;
    } vec_t;

    vec_t vecs[$];

    layer_sequencer #(
        .NUM_STAGES(3),
        .TIMEOUT_CYCLES(16),
        .CYC_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .stage_start(stage_start),
        .stage_done(stage_done),
        .stage_sel(stage_sel),
        .busy(busy),
        .done(done),
        .error(error),
        .last_cycles(last_cycles)
    );

    always #5 clk = ~clk;

    task automatic addVec(input logic rst, input logic st, input logic ab, input logic [2:0] sd,
                          input logic [2:0] ss, input logic [1:0] sel, input logic bsy,
                          input logic dn, input logic err, input logic [31:0] last);
        vec_t v;
        v.rst = rst; v.st = st; v.ab = ab; v.sd = sd;
        v.ss = ss; v.sel = sel; v.bsy = bsy; v.dn = dn; v.err = err; v.last = last;
        vecs.push_back(v);
    endtask

    task automatic addIdle(input int n, input logic [31:0] last);
        for (int i = 0; i < n; i++) addVec(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, last);
    endtask

    // Full frame, each stage finishing 5 cycles after its launch; foreign adds stray done/start pulses.
    task automatic addFrame(input logic [31:0] prev, input bit foreign);
        logic       st;
        logic [2:0] sd, ss;
        logic [1:0] sel;
        for (int c = 0; c <= 20; c++) begin
            st  = (c == 0) || (foreign && c == 10);
            sd  = (c == 6) ? 3'b001 : (c == 12) ? 3'b010 : (c == 18) ? 3'b100 : 3'b000;
            if (foreign && c == 3) sd = sd | 3'b100;
            if (foreign && c == 9) sd = sd | 3'b001;
            ss  = (c == 1) ? 3'b001 : (c == 7) ? 3'b010 : (c == 13) ? 3'b100 : 3'b000;
            sel = (c >= 7 && c <= 12) ? 2'd1 : (c >= 13 && c <= 18) ? 2'd2 : 2'd0;
            addVec(1'b0, st, 1'b0, sd, ss, sel, (c >= 1 && c <= 18), (c == 19), 1'b0,
                   (c >= 19) ? 32'd18 : prev);
        end
    endtask

    // Start together with abort in IDLE is dropped; then a frame aborted while stage 1 waits.
    task automatic addAbort(input logic [31:0] prev);
        addVec(1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, prev);
        addVec(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, prev);
        for (int c = 0; c <= 15; c++) begin
            addVec(1'b0, (c == 0), (c == 9),
                   (c == 6) ? 3'b001 : (c == 12) ? 3'b010 : 3'b000,
                   (c == 1) ? 3'b001 : (c == 7) ? 3'b010 : 3'b000,
                   (c >= 7 && c <= 9) ? 2'd1 : 2'd0,
                   (c >= 1 && c <= 9), 1'b0, 1'b0, prev);
        end
    endtask

    task automatic addResetMid(input logic [31:0] prev);
        for (int c = 0; c <= 14; c++) begin
            addVec((c == 8), (c == 0), 1'b0,
                   (c == 6) ? 3'b001 : (c == 12) ? 3'b010 : 3'b000,
                   (c == 1) ? 3'b001 : (c == 7) ? 3'b010 : 3'b000,
                   (c >= 7 && c <= 8) ? 2'd1 : 2'd0,
                   (c >= 1 && c <= 8), 1'b0, 1'b0, (c >= 9) ? 32'd0 : prev);
        end
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic addWatchdog();
        // Stage 0 hangs: FAULT from cycle 18, restart at 22, abort at 24.
        for (int c = 0; c <= 26; c++) begin
            addVec(1'b0, (c == 0) || (c == 22), (c == 24), 3'b000,
                   (c == 1 || c == 23) ? 3'b001 : 3'b000, 2'd0,
                   (c >= 1 && c <= 17) || (c >= 23 && c <= 24), 1'b0,
                   (c >= 18 && c <= 22), 32'd0);
        end
        // Done on the last allowed cycle is accepted.
        for (int c = 0; c <= 21; c++) begin
            addVec(1'b0, (c == 0), (c == 19), (c == 17) ? 3'b001 : 3'b000,
                   (c == 1) ? 3'b001 : (c == 18) ? 3'b010 : 3'b000,
                   (c >= 18 && c <= 19) ? 2'd1 : 2'd0,
                   (c >= 1 && c <= 19), 1'b0, 1'b0, 32'd0);
        end
    endtask
`else
    task automatic addWatchdog();
        // Without the watchdog a stage may hang forever; its late done still advances the frame.
        for (int c = 0; c <= 1005; c++) begin
            addVec(1'b0, (c == 0), (c == 1003), (c == 1001) ? 3'b001 : 3'b000,
                   (c == 1) ? 3'b001 : (c == 1002) ? 3'b010 : 3'b000,
                   (c >= 1002 && c <= 1003) ? 2'd1 : 2'd0,
                   (c >= 1 && c <= 1003), 1'b0, 1'b0, 32'd0);
        end
    endtask
`endif

    task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s vec %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        cmp("stage_start", idx, 32'(stage_start), 32'(v.ss));
        cmp("stage_sel", idx, 32'(stage_sel), 32'(v.sel));
        cmp("busy", idx, 32'(busy), 32'(v.bsy));
        cmp("done", idx, 32'(done), 32'(v.dn));
        cmp("error", idx, 32'(error), 32'(v.err));
        cmp("last_cycles", idx, last_cycles, v.last);
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        @(negedge clk);
        checkOutput(idx, v);
        reset      = v.rst;
        start      = v.st;
        abort      = v.ab;
        stage_done = v.sd;
    endtask

    initial begin
        addIdle(2, 32'd0);
        addFrame(32'd0, 1'b0);
        addFrame(32'd18, 1'b1);
        addAbort(32'd18);
        addFrame(32'd18, 1'b0);
        addResetMid(32'd18);
        addIdle(2, 32'd0);
        addWatchdog();
        addIdle(2, 32'd0);

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Frame-level controller that runs the inference layers (conv, maxpool, dense, argmax, …) strictly in order, one at a time. It issues a one-cycle start pulse to each stage, waits for that stage's done pulse, then launches the next. It drives `stage_sel` so top-level muxes give the active stage ownership of the shared BRAM ports. It also measures per-frame latency and can optionally flag a hung stage.

## Interface
Parameters:
- `NUM_STAGES`, 4: number of sequenced stages, ≥1; stage 0 runs first.
- `TIMEOUT_CYCLES`, 1_000_000: watchdog limit per stage, ≥2; used only with `SEQ_TIMEOUT_EN`.
- `CYC_W`, 32: width of `last_cycles`.

Derived:
- `STAGE_W` = max(1, $clog2(NUM_STAGES)).

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: frame request; accepted only in IDLE or FAULT.
- `abort`, in, 1: cancel the current frame.
- `stage_start`, out, NUM_STAGES: one-hot, one-cycle launch pulse per stage.
- `stage_done`, in, NUM_STAGES: per-stage done pulses.
- `stage_sel`, out, STAGE_W: index of the stage that owns the shared buffers.
- `busy`, out, 1: high while in LAUNCH or WAIT.
- `done`, out, 1: one-cycle frame-complete pulse.
- `error`, out, 1: watchdog fault; sticky.
- `last_cycles`, out, CYC_W: latency of the last completed frame.

## Operation
States and transitions:
- **IDLE**
  - `start` high → LAUNCH with `stage_sel`=0.
  - Cycle counter cleared to 0.
- **LAUNCH** (one cycle)
  - `stage_start[stage_sel]`=1; always goes to WAIT.
  - Per-stage wait counter cleared.
  - `stage_done` is ignored in this cycle.
- **WAIT**
  - `stage_done[stage_sel]` sampled high and `stage_sel` < NUM_STAGES-1 → `stage_sel`+1, go to LAUNCH.
  - `stage_done[stage_sel]` sampled high and `stage_sel` = NUM_STAGES-1 → `done`=1 next cycle, `last_cycles` updated, state IDLE, `stage_sel`=0.
  - `stage_done` bits of non-selected stages are ignored in every state.
- **FAULT**
  - `error`=1 and `busy`=0; `stage_sel` holds the hung stage.
  - `start` → clears `error`, enters LAUNCH with stage 0.
- **abort**, sampled high in LAUNCH, WAIT or FAULT:
  - Next cycle: IDLE, `stage_sel`=0, `error`=0.
  - No `done`, no further `stage_start`; `last_cycles` unchanged.
- Simultaneous-event priority: `reset` > `abort` > `stage_done`/timeout > `start`.
  - `start` while busy is ignored.
  - `start` and `abort` together in IDLE: start is ignored.
- Cycle counter:
  - Increments every cycle in LAUNCH/WAIT and saturates at all-ones.
  - `last_cycles` = counter value including the final done-sample cycle.

## Timing
- All outputs are registered.
- Reset values:
  - `stage_start`=0, `stage_sel`=0, `busy`=0, `done`=0, `error`=0, `last_cycles`=0.
  - State IDLE.
- `start` high in cycle t → `stage_start[0]`=1 and `busy`=1 in cycle t+1.
- `stage_done[k]` high in WAIT cycle d:
  - Not last stage: `stage_start[k+1]` in cycle d+1. This one-cycle gap between stages is guaranteed; `stage_sel` changes at the same edge.
  - Last stage: `done`=1 and `busy`=0 in cycle d+1.
- `stage_sel` is stable from the LAUNCH cycle through the done-sample cycle of that stage.
- A done pulse landing in the LAUNCH cycle is lost; stages must take at least 1 cycle after `stage_start`.
- `reset` mid-frame: all outputs return to reset values at the next edge; no `done`.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A per-stage counter runs in WAIT.
  - If `stage_start` pulses in cycle s and no `stage_done` is sampled in cycles s+1..s+TIMEOUT_CYCLES, the block enters FAULT and `error`=1 from cycle s+TIMEOUT_CYCLES+1.
  - A done sampled exactly in cycle s+TIMEOUT_CYCLES is accepted.
- `SEQ_TIMEOUT_EN` undefined:
  - No watchdog counter; FAULT is unreachable; `error` is tied to 0.
  - WAIT lasts indefinitely.

## Test plan
Benches use NUM_STAGES=3 and TIMEOUT_CYCLES=16.
- **Nominal frame:** `start` in cycle 0; each stage raises done 5 cycles after its `stage_start` → `stage_start` one-hot in cycles 1, 7, 13; `done` in cycle 19; `last_cycles`=18; `busy` high in cycles 1–18.
- **Foreign done:** `stage_done[2]` pulsed while stage 0 is active, and `start` pulsed mid-frame → both ignored; the sequence is identical to the nominal frame.
- **Abort:** `abort` in cycle 9 (stage 1 in WAIT) → cycle 10: `busy`=0, `stage_sel`=0; no `done`; `last_cycles` keeps its previous value; a subsequent `start` runs a normal frame.
- **Watchdog (with `SEQ_TIMEOUT_EN`):** stage 0 never completes → `error`=1 from cycle 18, `stage_sel`=0, no further `stage_start`. Then `start` → `error`=0, `stage_start[0]` next cycle. A done in cycle 17 instead completes stage 0 normally.
- **Watchdog off (`SEQ_TIMEOUT_EN` undefined):** stage 0 hangs 1000 cycles → `error` stays 0, `busy` stays 1; done in cycle 1001 → `stage_start[1]` in cycle 1002.
- **Reset mid-frame:** `reset` in cycle 8 → all outputs at reset values in cycle 9; no `done`.
